// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: decode control in, ROM address/data, and the fetched instruction out to decode.
interface fetch_unit_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  logic                  stall;
  logic                  redirect_valid;
  logic [31:0]           redirect_target;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0] imem_data;
  logic [DATA_WIDTH-1:0] inst;
  logic [31:0]           pc;
  logic [31:0]           pc_plus4;
  logic                  inst_valid;
  logic                  fetch_fault;
  logic [31:0]           fault_addr;

  modport master (
    input  stall, redirect_valid, redirect_target, imem_data,
    output imem_addr, inst, pc, pc_plus4, inst_valid, fetch_fault, fault_addr
  );

  modport slave (
    output stall, redirect_valid, redirect_target, imem_data,
    input  imem_addr, inst, pc, pc_plus4, inst_valid, fetch_fault, fault_addr
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, addresses the sync-read ROM from next-PC, halts on a fetch fault.
//   state | meaning
//   BOOT  | first cycle after reset, ROM addressed at RESET_PC
//   RUN   | fetching one instruction per cycle
//   HALT  | fault captured, waiting for reset
module fetch_unit #(
  parameter int          ADDR_WIDTH = 10,
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        inst_valid_q, inst_valid_d;
  logic        fetch_fault_q, fetch_fault_d;
  logic [31:0] fault_addr_q, fault_addr_d;
  logic [31:0] pc_next;
  logic        fault;

  always_comb begin
    pc_next       = pc_q;
    fault         = 1'b0;
    state_d       = state_q;
    pc_d          = pc_q;
    inst_valid_d  = inst_valid_q;
    fetch_fault_d = fetch_fault_q;
    fault_addr_d  = fault_addr_q;
    case (state_q)
      BOOT: begin
        pc_next      = RESET_PC;
        pc_d         = RESET_PC;
        inst_valid_d = 1'b1;
        state_d      = RUN;
      end
      RUN: begin
        if (bus.redirect_valid)  pc_next = bus.redirect_target;
        else if (bus.stall)      pc_next = pc_q;
        else                     pc_next = pc_q + 32'd4;
        fault = (pc_next[1:0] != 2'b00) || (pc_next[31:ADDR_WIDTH+2] != '0);
        if (fault) begin
          // pc stays on the last good instruction so the fault is debuggable
          fault_addr_d  = pc_next;
          fetch_fault_d = 1'b1;
          inst_valid_d  = 1'b0;
          state_d       = HALT;
        end else begin
          pc_d         = pc_next;
          inst_valid_d = 1'b1;
        end
      end
      default: begin
        pc_next      = pc_q;
        inst_valid_d = 1'b0;
        state_d      = HALT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      inst_valid_q  <= 1'b0;
      fetch_fault_q <= 1'b0;
      fault_addr_q  <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inst_valid_q  <= inst_valid_d;
      fetch_fault_q <= fetch_fault_d;
      fault_addr_q  <= fault_addr_d;
    end
  end

  assign bus.imem_addr   = fault ? pc_q[ADDR_WIDTH+1:2] : pc_next[ADDR_WIDTH+1:2];
  assign bus.inst        = inst_valid_q ? bus.imem_data : '0;
  assign bus.pc          = pc_q;
  assign bus.pc_plus4    = pc_q + 32'd4;
  assign bus.inst_valid  = inst_valid_q;
  assign bus.fetch_fault = fetch_fault_q;
  assign bus.fault_addr  = fault_addr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit with a behavioural sync-read ROM.
module tb_fetch_unit;
  localparam int AW = 10;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_unit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  fetch_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  logic [DW-1:0] rom [0:(1<<AW)-1];
  always @(posedge clk) bus.imem_data <= rst ? '0 : rom[bus.imem_addr];

  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic [31:0] p4;
    logic [31:0] inst;
    logic        f;
    logic [31:0] fa;
  } obs_t;

  typedef struct packed {
    logic        r;
    logic        s;
    logic        rv;
    logic [31:0] tgt;
    obs_t        exp;
  } stim_t;

  obs_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic obs_t mk(input logic v, input logic [31:0] p, input logic f, input logic [31:0] fa);
    obs_t o;
    o.v    = v;
    o.pc   = p;
    o.p4   = p + 32'd4;
    o.inst = v ? rom[p[AW+1:2]] : '0;
    o.f    = f;
    o.fa   = fa;
    return o;
  endfunction

  function automatic obs_t grab();
    obs_t o;
    o.v    = bus.inst_valid;
    o.pc   = bus.pc;
    o.p4   = bus.pc_plus4;
    o.inst = bus.inst;
    o.f    = bus.fetch_fault;
    o.fa   = bus.fault_addr;
    return o;
  endfunction

  function automatic stim_t st(input logic r, input logic s, input logic rv, input logic [31:0] t, input obs_t e);
    stim_t x;
    x.r = r; x.s = s; x.rv = rv; x.tgt = t; x.exp = e;
    return x;
  endfunction

  task automatic drive(input stim_t x);
    rst                 = x.r;
    bus.stall           = x.s;
    bus.redirect_valid  = x.rv;
    bus.redirect_target = x.tgt;
    sb.push_back(x.exp);
  endtask

  task automatic test_reset();
    stim_t q[$];
    obs_t e, g;
    q.push_back(st(1, 0, 0, 0, mk(0, 0, 0, 0)));
    q.push_back(st(1, 1, 1, 32'h80, mk(0, 0, 0, 0)));
    q.push_back(st(0, 0, 0, 0, mk(1, 0, 0, 0)));
    q.push_back(st(0, 0, 0, 0, mk(1, 4, 0, 0)));
    q.push_back(st(0, 0, 0, 0, mk(1, 8, 0, 0)));
    q.push_back(st(0, 0, 0, 0, mk(1, 12, 0, 0)));
    foreach (q[i]) begin
      drive(q[i]);
      @(posedge clk); #1;
      e = sb.pop_front(); g = grab(); n_vec++;
      if (g !== e) begin
        n_err++;
        $display("FAIL reset_seq[%0d]: got v=%b pc=%h p4=%h inst=%h f=%b fa=%h, need v=%b pc=%h p4=%h inst=%h f=%b fa=%h",
                 i, g.v, g.pc, g.p4, g.inst, g.f, g.fa, e.v, e.pc, e.p4, e.inst, e.f, e.fa);
      end
    end
  endtask

  task automatic test_stall();
    stim_t q[$];
    obs_t e, g;
    q.push_back(st(1, 0, 0, 0, mk(0, 0, 0, 0)));
    q.push_back(st(0, 0, 0, 0, mk(1, 0, 0, 0)));
    q.push_back(st(0, 0, 0, 0, mk(1, 4, 0, 0)));
    q.push_back(st(0, 1, 0, 0, mk(1, 4, 0, 0)));
    q.push_back(st(0, 1, 0, 0, mk(1, 4, 0, 0)));
    q.push_back(st(0, 1, 0, 0, mk(1, 4, 0, 0)));
    q.push_back(st(0, 0, 0, 0, mk(1, 8, 0, 0)));
    foreach (q[i]) begin
      drive(q[i]);
      @(posedge clk); #1;
      e = sb.pop_front(); g = grab(); n_vec++;
      if (g !== e) begin
        n_err++;
        $display("FAIL stall[%0d]: got v=%b pc=%h inst=%h f=%b fa=%h, need v=%b pc=%h inst=%h f=%b fa=%h",
                 i, g.v, g.pc, g.inst, g.f, g.fa, e.v, e.pc, e.inst, e.f, e.fa);
      end
      if (q[i].s) begin
        n_vec++;
        if (bus.imem_addr !== 10'd1) begin
          n_err++;
          $display("FAIL stall_addr[%0d]: got %0d need 1", i, bus.imem_addr);
        end
      end
    end
  endtask

  task automatic test_redirect_stall();
    stim_t q[$];
    obs_t e, g;
    q.push_back(st(0, 1, 1, 32'h20, mk(1, 32'h20, 0, 0)));
    q.push_back(st(0, 0, 0, 0, mk(1, 32'h24, 0, 0)));
    foreach (q[i]) begin
      drive(q[i]);
      @(posedge clk); #1;
      e = sb.pop_front(); g = grab(); n_vec++;
      if (g !== e) begin
        n_err++;
        $display("FAIL redirect_stall[%0d]: got v=%b pc=%h inst=%h, need v=%b pc=%h inst=%h",
                 i, g.v, g.pc, g.inst, e.v, e.pc, e.inst);
      end
    end
  endtask

  task automatic test_misaligned();
    stim_t q[$];
    obs_t e, g;
    q.push_back(st(0, 0, 1, 32'h22, mk(0, 32'h24, 1, 32'h22)));
    for (int k = 0; k < 10; k++)
      q.push_back(st(0, k[0], 1, 32'h40 + 32'(k) * 4, mk(0, 32'h24, 1, 32'h22)));
    q.push_back(st(1, 0, 1, 32'h40, mk(0, 0, 0, 0)));
    q.push_back(st(0, 0, 0, 0, mk(1, 0, 0, 0)));
    foreach (q[i]) begin
      drive(q[i]);
      @(posedge clk); #1;
      e = sb.pop_front(); g = grab(); n_vec++;
      if (g !== e) begin
        n_err++;
        $display("FAIL misaligned[%0d]: got v=%b pc=%h inst=%h f=%b fa=%h, need v=%b pc=%h inst=%h f=%b fa=%h",
                 i, g.v, g.pc, g.inst, g.f, g.fa, e.v, e.pc, e.inst, e.f, e.fa);
      end
    end
  endtask

  task automatic test_runoff();
    stim_t q[$];
    obs_t e, g;
    q.push_back(st(0, 0, 1, 32'hFFC, mk(1, 32'hFFC, 0, 0)));
    q.push_back(st(0, 0, 0, 0, mk(0, 32'hFFC, 1, 32'h1000)));
    q.push_back(st(0, 0, 0, 0, mk(0, 32'hFFC, 1, 32'h1000)));
    q.push_back(st(1, 0, 0, 0, mk(0, 0, 0, 0)));
    q.push_back(st(0, 0, 0, 0, mk(1, 0, 0, 0)));
    q.push_back(st(0, 0, 1, 32'hFFFF_FFFC, mk(0, 0, 1, 32'hFFFF_FFFC)));
    foreach (q[i]) begin
      drive(q[i]);
      @(posedge clk); #1;
      e = sb.pop_front(); g = grab(); n_vec++;
      if (g !== e) begin
        n_err++;
        $display("FAIL runoff[%0d]: got v=%b pc=%h p4=%h f=%b fa=%h, need v=%b pc=%h p4=%h f=%b fa=%h",
                 i, g.v, g.pc, g.p4, g.f, g.fa, e.v, e.pc, e.p4, e.f, e.fa);
      end
    end
  endtask

  task automatic test_mid_reset();
    stim_t q[$];
    obs_t e, g;
    q.push_back(st(1, 0, 0, 0, mk(0, 0, 0, 0)));
    q.push_back(st(0, 0, 0, 0, mk(1, 0, 0, 0)));
    q.push_back(st(0, 0, 1, 32'h40, mk(1, 32'h40, 0, 0)));
    q.push_back(st(1, 0, 1, 32'h80, mk(0, 0, 0, 0)));
    q.push_back(st(0, 1, 1, 32'h80, mk(1, 0, 0, 0)));
    foreach (q[i]) begin
      drive(q[i]);
      @(posedge clk); #1;
      e = sb.pop_front(); g = grab(); n_vec++;
      if (g !== e) begin
        n_err++;
        $display("FAIL mid_reset[%0d]: got v=%b pc=%h inst=%h f=%b, need v=%b pc=%h inst=%h f=%b",
                 i, g.v, g.pc, g.inst, g.f, e.v, e.pc, e.inst, e.f);
      end
      if (q[i].r) begin
        n_vec++;
        if (bus.imem_addr !== 10'd0) begin
          n_err++;
          $display("FAIL boot_addr[%0d]: got %0d need 0", i, bus.imem_addr);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    stim_t q[$];
    obs_t e, g;
    logic [31:0] t;
    for (int k = 0; k < 12; k++) begin
      t = {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
      q.push_back(st(0, 1'($urandom_range(0, 1)), 1, t, mk(1, t, 0, 0)));
    end
    q.push_back(st(0, 0, 0, 0, mk(1, t + 32'd4, t == 32'hFFC, t == 32'hFFC ? 32'h1000 : 32'h0)));
    foreach (q[i]) begin
      drive(q[i]);
      @(posedge clk); #1;
      e = sb.pop_front(); g = grab(); n_vec++;
      if (i == q.size() - 1 && e.f) begin
        e.pc = t; e.p4 = t + 32'd4; e.v = 1'b0; e.inst = '0;
      end
      if (g !== e) begin
        n_err++;
        $display("FAIL back_to_back[%0d]: got v=%b pc=%h inst=%h f=%b, need v=%b pc=%h inst=%h f=%b",
                 i, g.v, g.pc, g.inst, g.f, e.v, e.pc, e.inst, e.f);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) rom[i] = 32'hA500_0000 ^ (32'(i) * 32'h0001_0103);
    rom[0] = 32'd11;
    rom[1] = 32'd22;
    rom[2] = 32'd33;
    rom[3] = 32'd44;
    rst                 = 1'b1;
    bus.stall           = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = 32'd0;
    #1;
    test_reset();
    test_stall();
    test_redirect_stall();
    test_misaligned();
    test_reset();
    test_runoff();
    test_mid_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
